gpio_pad_bank: RTL and testbench

GPIO_PAD_BANK -- requirements
Module: gpio_pad_bank

---
 rtl/gpio_pad_defs.sv | 44 ++++
 rtl/gpio_pad_debounce.sv | 80 ++++++++
 rtl/gpio_pad_bank.sv | 146 ++++++++++++++
 tb/tb_gpio_pad_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_defs.sv
// -----------------------------------------------------------------------------
// gpio_pad_defs
//   Shared definitions for the GPIO pad bank: default bank geometry, the
//   post-reset arming delay, the pad drive mode encoding and the per-pin
//   drive helpers used by the output path.
// -----------------------------------------------------------------------------
package gpio_pad_defs;

  // Default number of pad channels in a bank (legal range 1..32).
  localparam int GPIO_WIDTH_DEF      = 8;

  // Default width of the debounce threshold and per-pin counters.
  localparam int GPIO_DEBOUNCE_W_DEF = 16;

  // Cycles after reset release before edge detection is enabled. This
  // covers the two synchroniser flops plus one cycle for stable_q to pick
  // up the settled pad level, so that a pad held through reset is absorbed
  // silently instead of being seen as an edge.
  localparam int GPIO_ARM_DELAY      = 3;
  localparam int GPIO_ARM_CNT_W      = $clog2(GPIO_ARM_DELAY + 1);

  // Pad driver mode, one bit per pin on the register interface.
  typedef enum logic {
    PAD_PUSH_PULL  = 1'b0,
    PAD_OPEN_DRAIN = 1'b1
  } pad_mode_e;

  // Level presented on the pad.  An open-drain pin never drives high; it
  // only ever pulls low, so its data bit is tied to 0 and the level is
  // carried entirely by the enable.
  function automatic logic pad_drive_level(input pad_mode_e mode,
                                           input logic      level);
    return (mode == PAD_OPEN_DRAIN) ? 1'b0 : level;
  endfunction

  // Driver enable presented on the pad.  Open-drain releases the pad
  // (high-Z, pulled up on the board) when a 1 is requested.
  function automatic logic pad_drive_enable(input pad_mode_e mode,
                                            input logic      level,
                                            input logic      enable);
    return (mode == PAD_OPEN_DRAIN) ? (enable & ~level) : enable;
  endfunction

endpackage : gpio_pad_defs

// File: rtl/gpio_pad_debounce.sv
// -----------------------------------------------------------------------------
// gpio_pad_debounce
//   Single-pin input conditioner: two-flop synchroniser, saturating-free
//   debounce counter, debounced level register and one-cycle edge pulses.
//
// Ports
//   clk_i        in   rising-edge clock
//   rst_i        in   asynchronous active-high reset
//   armed_i      in   0 = track the synchronised level directly, no edges
//   pad_i        in   raw asynchronous pad level
//   threshold_i  in   debounce threshold D (DEBOUNCE_W bits)
//   level_o      out  debounced level (stable_q)
//   rise_o       out  one-cycle pulse the cycle after stable_q goes 0->1
//   fall_o       out  one-cycle pulse the cycle after stable_q goes 1->0
// -----------------------------------------------------------------------------
module gpio_pad_debounce #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  armed_i,
  input  logic                  pad_i,
  input  logic [DEBOUNCE_W-1:0] threshold_i,
  output logic                  level_o,
  output logic                  rise_o,
  output logic                  fall_o
);

  logic                  sync_meta_q;
  logic                  sync_q;
  logic                  stable_q;
  logic                  rise_q;
  logic                  fall_q;
  logic [DEBOUNCE_W-1:0] cnt_q;

  logic differ;
  logic expired;

  assign differ  = sync_q ^ stable_q;
  // A >= compare (not ==) so that lowering the threshold below a count
  // already reached commits the new level on the very next cycle.  The
  // counter only increments while below the threshold, so it cannot wrap.
  assign expired = (cnt_q >= threshold_i);

  // Stage 0 -> 1: synchroniser, then debounce decision on the synchronised level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      stable_q    <= 1'b0;
      cnt_q       <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sync_meta_q <= pad_i;
      sync_q      <= sync_meta_q;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      if (!armed_i) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
      end else if (!differ) begin
        // Level returned before the threshold: the glitch is forgotten.
        cnt_q <= '0;
      end else if (expired) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
        rise_q   <= sync_q;
        fall_q   <= ~sync_q;
      end else begin
        cnt_q <= cnt_q + DEBOUNCE_W'(1);
      end
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : gpio_pad_debounce

// File: rtl/gpio_pad_bank.sv
// -----------------------------------------------------------------------------
// gpio_pad_bank
//   Bank of WIDTH general-purpose pads.  Each pin has a registered output
//   path (push-pull or open-drain), a synchronised and debounced input path,
//   and sticky rise/fall interrupt status with write-1-to-clear.
//
// Ports
//   clk_i                 in   rising-edge clock
//   rst_i                 in   asynchronous active-high reset
//   pad_in_i              in   raw pad levels                    [WIDTH]
//   pad_out_o             out  registered pad drive level        [WIDTH]
//   pad_oe_o              out  registered pad drive enable       [WIDTH]
//   gpio_output_i         in   requested output level            [WIDTH]
//   gpio_output_enable_i  in   requested drive enable            [WIDTH]
//   gpio_open_drain_i     in   1 = open-drain, 0 = push-pull     [WIDTH]
//   debounce_cycles_i     in   debounce threshold D              [DEBOUNCE_W]
//   gpio_input_o          out  debounced input level             [WIDTH]
//   irq_rise_en_i         in   rising-edge interrupt enable      [WIDTH]
//   irq_fall_en_i         in   falling-edge interrupt enable     [WIDTH]
//   irq_clear_i           in   write-1-to-clear status pulse     [WIDTH]
//   irq_status_o          out  sticky edge status                [WIDTH]
//   irq_o                 out  OR of all status bits
// -----------------------------------------------------------------------------
module gpio_pad_bank
  import gpio_pad_defs::*;
#(
  parameter int WIDTH      = GPIO_WIDTH_DEF,
  parameter int DEBOUNCE_W = GPIO_DEBOUNCE_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      pad_in_i,
  output logic [WIDTH-1:0]      pad_out_o,
  output logic [WIDTH-1:0]      pad_oe_o,
  input  logic [WIDTH-1:0]      gpio_output_i,
  input  logic [WIDTH-1:0]      gpio_output_enable_i,
  input  logic [WIDTH-1:0]      gpio_open_drain_i,
  input  logic [DEBOUNCE_W-1:0] debounce_cycles_i,
  output logic [WIDTH-1:0]      gpio_input_o,
  input  logic [WIDTH-1:0]      irq_rise_en_i,
  input  logic [WIDTH-1:0]      irq_fall_en_i,
  input  logic [WIDTH-1:0]      irq_clear_i,
  output logic [WIDTH-1:0]      irq_status_o,
  output logic                  irq_o
);

  // ---------------------------------------------------------------------------
  // Output path
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pad_out_d;
  logic [WIDTH-1:0] pad_oe_d;
  logic [WIDTH-1:0] pad_out_q;
  logic [WIDTH-1:0] pad_oe_q;

  always_comb begin
    pad_out_d = '0;
    pad_oe_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pad_out_d[i] = pad_drive_level(pad_mode_e'(gpio_open_drain_i[i]),
                                     gpio_output_i[i]);
      pad_oe_d[i]  = pad_drive_enable(pad_mode_e'(gpio_open_drain_i[i]),
                                      gpio_output_i[i],
                                      gpio_output_enable_i[i]);
    end
  end

  // Stage 0 -> 1: pad driver registers (reset leaves every pin high-Z)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
    end
  end

  assign pad_out_o = pad_out_q;
  assign pad_oe_o  = pad_oe_q;

  // ---------------------------------------------------------------------------
  // Arming: hold off debouncing and edge detection until the synchronisers
  // have flushed the reset value, so the first real pad level is adopted
  // without generating an event.
  // ---------------------------------------------------------------------------
  logic [GPIO_ARM_CNT_W-1:0] arm_cnt_q;
  logic                      armed_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else if (!armed_q) begin
      arm_cnt_q <= arm_cnt_q + GPIO_ARM_CNT_W'(1);
      if (arm_cnt_q == GPIO_ARM_CNT_W'(GPIO_ARM_DELAY - 1)) begin
        armed_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input path: one conditioner per pin
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_pad_debounce #(
      .DEBOUNCE_W (DEBOUNCE_W)
    ) u_debounce (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .armed_i     (armed_q),
      .pad_i       (pad_in_i[g]),
      .threshold_i (debounce_cycles_i),
      .level_o     (stable[g]),
      .rise_o      (rise[g]),
      .fall_o      (fall[g])
    );
  end

  assign gpio_input_o = stable;

  // ---------------------------------------------------------------------------
  // Interrupt status
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] irq_set;
  logic [WIDTH-1:0] irq_status_q;

  // Enables only gate new events; a bit already latched stays until cleared.
  assign irq_set = (rise & irq_rise_en_i) | (fall & irq_fall_en_i);

  // Stage 1 -> 2: sticky status, a coincident set beats the clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_status_q <= '0;
    end else begin
      irq_status_q <= irq_set | (irq_status_q & ~irq_clear_i);
    end
  end

  assign irq_status_o = irq_status_q;
  assign irq_o        = |irq_status_q;

endmodule : gpio_pad_bank

// File: tb/tb_gpio_pad_bank.sv
// -----------------------------------------------------------------------------
// tb_gpio_pad_bank
//   Directed scenarios followed by randomized traffic; every cycle all DUT
//   outputs are compared against a timestamp-based reference model.
// -----------------------------------------------------------------------------
module tb_gpio_pad_bank;

  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [W-1:0]  pad_in_i = '0;
  logic [W-1:0]  pad_out_o;
  logic [W-1:0]  pad_oe_o;
  logic [W-1:0]  gpio_output_i = '0;
  logic [W-1:0]  gpio_output_enable_i = '0;
  logic [W-1:0]  gpio_open_drain_i = '0;
  logic [DW-1:0] debounce_cycles_i = '0;
  logic [W-1:0]  gpio_input_o;
  logic [W-1:0]  irq_rise_en_i = '0;
  logic [W-1:0]  irq_fall_en_i = '0;
  logic [W-1:0]  irq_clear_i = '0;
  logic [W-1:0]  irq_status_o;
  logic          irq_o;

  int n_checks = 0;
  int n_errors = 0;

  gpio_pad_bank #(
    .WIDTH      (W),
    .DEBOUNCE_W (DW)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .pad_in_i             (pad_in_i),
    .pad_out_o            (pad_out_o),
    .pad_oe_o             (pad_oe_o),
    .gpio_output_i        (gpio_output_i),
    .gpio_output_enable_i (gpio_output_enable_i),
    .gpio_open_drain_i    (gpio_open_drain_i),
    .debounce_cycles_i    (debounce_cycles_i),
    .gpio_input_o         (gpio_input_o),
    .irq_rise_en_i        (irq_rise_en_i),
    .irq_fall_en_i        (irq_fall_en_i),
    .irq_clear_i          (irq_clear_i),
    .irq_status_o         (irq_status_o),
    .irq_o                (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. Time is counted in clock edges since reset release.
  // A pin's debounced level flips at edge t when the synchronised level
  // (pad as sampled two edges earlier) has disagreed with it at every edge
  // from run_start up to t and t - run_start >= D.
  int       m_edges;
  bit [W-1:0] m_h1, m_h2;          // pad sampled one / two edges ago
  bit [W-1:0] m_stable, m_status, m_out, m_oe;
  int       m_run_start [W];
  int       m_flip_t    [W];
  bit       m_flip_dir  [W];

  task automatic model_reset();
    m_edges  = 0;
    m_h1     = '0;
    m_h2     = '0;
    m_stable = '0;
    m_status = '0;
    m_out    = '0;
    m_oe     = '0;
    for (int i = 0; i < W; i++) begin
      m_run_start[i] = -1;
      m_flip_t[i]    = -10;
      m_flip_dir[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    int  t;
    int  d;
    bit  synced;
    bit  ev;
    m_edges++;
    t = m_edges;
    d = int'(debounce_cycles_i);
    for (int i = 0; i < W; i++) begin
      // Status reacts to a level change committed on the previous edge.
      ev = (m_flip_t[i] == t - 1) &&
           ((m_flip_dir[i] && irq_rise_en_i[i]) || (!m_flip_dir[i] && irq_fall_en_i[i]));
      if (ev)                  m_status[i] = 1'b1;
      else if (irq_clear_i[i]) m_status[i] = 1'b0;

      synced = m_h2[i];
      if (t <= 3) begin
        m_stable[i]    = synced;
        m_run_start[i] = -1;
      end else if (synced == m_stable[i]) begin
        m_run_start[i] = -1;
      end else begin
        if (m_run_start[i] < 0) m_run_start[i] = t;
        if (t - m_run_start[i] >= d) begin
          m_stable[i]    = synced;
          m_flip_t[i]    = t;
          m_flip_dir[i]  = synced;
          m_run_start[i] = -1;
        end
      end

      if (gpio_open_drain_i[i]) begin
        m_out[i] = 1'b0;
        m_oe[i]  = gpio_output_enable_i[i] & ~gpio_output_i[i];
      end else begin
        m_out[i] = gpio_output_i[i];
        m_oe[i]  = gpio_output_enable_i[i];
      end
    end
    m_h2 = m_h1;
    m_h1 = pad_in_i;
  endtask

  task automatic cmp_model();
    chk("model pad_out",    32'(pad_out_o),    32'(m_out));
    chk("model pad_oe",     32'(pad_oe_o),     32'(m_oe));
    chk("model gpio_input", 32'(gpio_input_o), 32'(m_stable));
    chk("model irq_status", 32'(irq_status_o), 32'(m_status));
    chk("model irq",        32'(irq_o),        32'(|m_status));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else       model_edge();
    @(negedge clk_i);
    cmp_model();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();

    // Reset state, pads held high through reset, all edge enables on.
    @(negedge clk_i);
    chk("reset pad_out",    32'(pad_out_o),    32'h0);
    chk("reset pad_oe",     32'(pad_oe_o),     32'h0);
    chk("reset gpio_input", 32'(gpio_input_o), 32'h0);
    chk("reset irq_status", 32'(irq_status_o), 32'h0);
    chk("reset irq",        32'(irq_o),        32'h0);
    pad_in_i      = 8'hFF;
    irq_rise_en_i = 8'hFF;
    irq_fall_en_i = 8'hFF;
    steps(2);
    rst_i = 1'b0;
    steps(5);
    chk("armed gpio_input", 32'(gpio_input_o), 32'hFF);
    chk("armed no irq",     32'(irq_status_o), 32'h00);

    // Drop all pads, let the falls land, then clear them.
    debounce_cycles_i = 16'd4;
    pad_in_i = 8'h00;
    steps(10);
    chk("falls latched", 32'(irq_status_o), 32'hFF);
    irq_clear_i = 8'hFF;
    step();
    irq_clear_i = 8'h00;
    chk("falls cleared", 32'(irq_status_o), 32'h00);

    // D = 4: a 4-cycle pulse on pin 2 is rejected.
    pad_in_i[2] = 1'b1;
    steps(4);
    pad_in_i[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("glitch rejected", 32'(gpio_input_o[2]), 32'h0);
    end
    // A held level on pin 2 lands after 2 + D + 1 = 7 cycles.
    pad_in_i[2] = 1'b1;
    steps(6);
    chk("pin2 before 7", 32'(gpio_input_o[2]), 32'h0);
    step();
    chk("pin2 at 7",     32'(gpio_input_o[2]), 32'h1);
    chk("pin2 irq at 7", 32'(irq_status_o[2]), 32'h0);
    step();
    chk("pin2 irq at 8", 32'(irq_status_o[2]), 32'h1);

    // Open-drain pin 5.
    gpio_open_drain_i    = 8'h20;
    gpio_output_enable_i = 8'h20;
    gpio_output_i        = 8'h20;
    step();
    chk("od high oe", 32'(pad_oe_o[5]), 32'h0);
    gpio_output_i = 8'h00;
    step();
    chk("od low oe",  32'(pad_oe_o[5]),  32'h1);
    chk("od low out", 32'(pad_out_o[5]), 32'h0);
    gpio_output_i = 8'h20;
    step();
    chk("od release oe", 32'(pad_oe_o[5]), 32'h0);

    // Pin 0: set status via a rise, then collide a fall with a clear.
    debounce_cycles_i = 16'd0;
    pad_in_i[0] = 1'b1;
    steps(5);
    chk("pin0 rise status", 32'(irq_status_o[0]), 32'h1);
    pad_in_i[0] = 1'b0;
    steps(3);
    irq_clear_i = 8'hFF;
    step();
    irq_clear_i = 8'h00;
    chk("set beats clear", 32'(irq_status_o), 32'h01);
    irq_clear_i = 8'hFF;
    step();
    irq_clear_i = 8'h00;
    chk("plain clear status", 32'(irq_status_o), 32'h00);
    chk("plain clear irq",    32'(irq_o),        32'h0);

    // Pin 7: threshold lowered from 100 to 2 with the count at 50.
    debounce_cycles_i = 16'd100;
    pad_in_i[7] = 1'b1;
    steps(52);
    chk("pin7 still counting", 32'(gpio_input_o[7]), 32'h0);
    debounce_cycles_i = 16'd2;
    step();
    chk("pin7 after lower D", 32'(gpio_input_o[7]), 32'h1);

    // Asynchronous reset in the middle of a debounce.
    debounce_cycles_i    = 16'd10;
    gpio_open_drain_i    = 8'h00;
    gpio_output_enable_i = 8'hFF;
    gpio_output_i        = 8'hA5;
    pad_in_i             = 8'h3C;
    steps(5);
    chk("pre-reset irq", 32'(irq_o), 32'h1);
    #1 rst_i = 1'b1;
    model_reset();
    #1;
    chk("async rst pad_out",    32'(pad_out_o),    32'h0);
    chk("async rst pad_oe",     32'(pad_oe_o),     32'h0);
    chk("async rst gpio_input", 32'(gpio_input_o), 32'h0);
    chk("async rst irq_status", 32'(irq_status_o), 32'h0);
    chk("async rst irq",        32'(irq_o),        32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    steps(6);

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      logic [W-1:0] flips;
      flips = '0;
      for (int b = 0; b < W; b++) flips[b] = ($urandom_range(0, 7) == 0);
      pad_in_i ^= flips;
      if ($urandom_range(0, 63) == 0) debounce_cycles_i = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 31) == 0) begin
        irq_rise_en_i = W'($urandom);
        irq_fall_en_i = W'($urandom);
      end
      gpio_output_i        = W'($urandom);
      gpio_output_enable_i = W'($urandom);
      gpio_open_drain_i    = W'($urandom);
      irq_clear_i          = ($urandom_range(0, 15) == 0) ? W'($urandom) : '0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_gpio_pad_bank
